fast_slow_hold_buffer: RTL and testbench

- Single-clock block in the fast (ADC/sample) domain that feeds a consumer running on a slower, unrelated clock, such as the VGA pixel-side logic.
- Buffers incoming samples in a small FIFO.
- Tracks the consumer clock by synchronizing it as a data signal.
- Advances `data_out` once per consumer period, just after the consumer's rising edge, so `data_out` is stable for the whole consumer period.

---
 rtl/fast_slow_hold_buffer.sv | 135 +++++++++++++
 tb/tb_fast_slow_hold_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fast_slow_hold_buffer.sv
// Sample-domain FIFO feeding a slower consumer: data_out advances once per consumer period,
// shortly after the synchronized consumer clock rises, so it holds for the whole consumer period.
module fast_slow_hold_buffer #(
  parameter int N           = 12,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     slow_clk,
  input  logic [N-1:0]             data_in,
  input  logic                     data_valid,
  input  logic                     overflow_clr,
  output logic [N-1:0]             data_out,
  output logic                     out_update,
  output logic                     stale,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [0:0] PRIME = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  // Handshake: data_valid is a push with no back-pressure. A push is taken when the FIFO
  // has room or is popped in the same cycle; otherwise the word is dropped and overflow is flagged.

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   slow_rise;

  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  data_out_q, data_out_d;
  logic          out_update_q, out_update_d;
  logic          stale_q, stale_d;
  logic          overflow_q, overflow_d;
  logic [0:0]    state_q, state_d;

  logic push, pop, drop;

  // slow_clk is sampled purely as a level; the rise is detected one flop past the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign slow_rise = sync_q[SYNC_STAGES-1] & ~edge_q;

  // Full/empty come only from count; a pop frees the slot a same-cycle write needs.
  assign pop  = slow_rise && (count_q != '0);
  assign push = data_valid && ((count_q != FULL) || pop);
  assign drop = data_valid && !push;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    out_update_d = 1'b0;
    stale_d      = stale_q;
    overflow_d   = overflow_q;
    state_d      = state_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (pop) begin
      rd_ptr_d     = rd_ptr_q + AW'(1);
      data_out_d   = mem_q[rd_ptr_q];
      out_update_d = 1'b1;
      stale_d      = 1'b0;
      state_d      = RUN;
    end else if (slow_rise) begin
      stale_d = 1'b1;
    end

    count_d = count_q + CW'(push) - CW'(pop);

    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      out_update_q <= 1'b0;
      stale_q      <= 1'b1;
      overflow_q   <= 1'b0;
      state_q      <= PRIME;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      out_update_q <= out_update_d;
      stale_q      <= stale_d;
      overflow_q   <= overflow_d;
      state_q      <= state_d;
    end
  end

  // Storage needs no reset: only words between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out   = data_out_q;
  assign out_update = out_update_q;
  assign stale      = stale_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_fast_slow_hold_buffer.sv
// Directed bench for fast_slow_hold_buffer: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_fast_slow_hold_buffer;

  localparam int N    = 12;
  localparam int DEPTH = 4;
  localparam int SYNC = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          slow_clk;
  logic [N-1:0]  data_in;
  logic          data_valid;
  logic          overflow_clr;
  logic [N-1:0]  data_out;
  logic          out_update;
  logic          stale;
  logic [2:0]    fifo_count;
  logic          overflow;
  logic          state_dbg;

  int checks   = 0;
  int failures = 0;

  int pulses, first_at, changes;

  fast_slow_hold_buffer #(.N(N), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .slow_clk     (slow_clk),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .overflow_clr (overflow_clr),
    .data_out     (data_out),
    .out_update   (out_update),
    .stale        (stale),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 16-cycle consumer period (8 high, 8 low) with no writes.
  task automatic slow_period(output int n_pulses, output int first, output int n_changes);
    logic [N-1:0] prev;
    prev      = data_out;
    n_pulses  = 0;
    first     = -1;
    n_changes = 0;
    slow_clk  = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (out_update) begin
        n_pulses++;
        if (first < 0) first = i;
      end
      if (data_out !== prev) n_changes++;
      prev = data_out;
      if (i == 8) slow_clk = 1'b0;
    end
  endtask

  task automatic write_one(input logic [N-1:0] d);
    data_valid = 1'b1;
    data_in    = d;
    tick();
    data_valid = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    slow_clk     = 1'b0;
    data_in      = '0;
    data_valid   = 1'b0;
    overflow_clr = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_out_update", 32'(out_update), 32'h0);
    chk("rst_stale", 32'(stale), 32'h1);
    chk("rst_count", 32'(fifo_count), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'h0);
    reset_n = 1'b1;
    tick();

    // Idle consumer periods with nothing buffered
    for (int p = 0; p < 5; p++) begin
      slow_period(pulses, first_at, changes);
      chk("idle_pulses", 32'(pulses), 32'h0);
    end
    chk("idle_data_out", 32'(data_out), 32'h0);
    chk("idle_stale", 32'(stale), 32'h1);
    chk("idle_count", 32'(fifo_count), 32'h0);
    chk("idle_state", 32'(state_dbg), 32'h0);

    // Single word, one consumer edge
    tick();
    write_one(12'h123);
    chk("single_count_in", 32'(fifo_count), 32'h1);
    for (int i = 0; i < 7; i++) tick();
    slow_period(pulses, first_at, changes);
    chk("single_pulses", 32'(pulses), 32'h1);
    chk("single_latency_ok", 32'((first_at >= SYNC + 1) && (first_at <= SYNC + 3)), 32'h1);
    chk("single_changes", 32'(changes), 32'h1);
    chk("single_data_out", 32'(data_out), 32'h123);
    chk("single_stale", 32'(stale), 32'h0);
    chk("single_count_out", 32'(fifo_count), 32'h0);
    chk("single_state", 32'(state_dbg), 32'h1);

    // Burst into a full FIFO with no consumer edges
    data_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      data_in = 12'(k);
      tick();
      chk("burst_count", 32'(fifo_count), 32'((k < DEPTH) ? k : DEPTH));
      if (k == 4) chk("burst_ovf_not_yet", 32'(overflow), 32'h0);
    end
    data_valid = 1'b0;
    chk("burst_overflow", 32'(overflow), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      slow_period(pulses, first_at, changes);
      chk("burst_pulses", 32'(pulses), 32'h1);
      chk("burst_data_out", 32'(data_out), 32'(k));
      chk("burst_stale", 32'(stale), 32'h0);
    end
    slow_period(pulses, first_at, changes);
    chk("empty_edge_pulses", 32'(pulses), 32'h0);
    chk("empty_edge_stale", 32'(stale), 32'h1);
    chk("empty_edge_data_out", 32'(data_out), 32'h4);
    chk("ovf_sticky", 32'(overflow), 32'h1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'h0);

    // Continuous writes; the consumer edge pops exactly when count reaches DEPTH
    data_valid = 1'b1;
    data_in = 12'h0B0; tick();
    data_in = 12'h0B1; tick();
    data_in = 12'h0B2; slow_clk = 1'b1; tick();
    data_in = 12'h0B3; tick();
    chk("full_before_pop", 32'(fifo_count), 32'h4);
    data_in = 12'h0B4; tick();
    data_valid = 1'b0;
    chk("coinc_update", 32'(out_update), 32'h1);
    chk("coinc_data_out", 32'(data_out), 32'h0B0);
    chk("coinc_count", 32'(fifo_count), 32'h4);
    chk("coinc_overflow", 32'(overflow), 32'h0);
    for (int i = 0; i < 5; i++) tick();
    slow_clk = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("coinc_count_hold", 32'(fifo_count), 32'h4);

    // Drop and clear in the same cycle: set wins
    data_valid = 1'b1; data_in = 12'h0BF; overflow_clr = 1'b1;
    tick();
    data_valid = 1'b0;
    chk("set_wins_ovf", 32'(overflow), 32'h1);
    chk("set_wins_count", 32'(fifo_count), 32'h4);
    tick();
    overflow_clr = 1'b0;
    chk("clr_after_drop", 32'(overflow), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      slow_period(pulses, first_at, changes);
      chk("coinc_drain", 32'(data_out), 32'h0B0 + 32'(k));
    end
    chk("coinc_drained", 32'(fifo_count), 32'h0);

    // Stream 8 words, one per consumer period, across pointer wrap
    for (int k = 0; k < 8; k++) begin
      write_one(12'h0A0 + 12'(k));
      slow_period(pulses, first_at, changes);
      chk("stream_pulses", 32'(pulses), 32'h1);
      chk("stream_data_out", 32'(data_out), 32'h0A0 + 32'(k));
      chk("stream_stale", 32'(stale), 32'h0);
    end
    chk("stream_overflow", 32'(overflow), 32'h0);

    // Asynchronous reset with words buffered
    write_one(12'h0A5);
    slow_period(pulses, first_at, changes);
    chk("pre_rst_data_out", 32'(data_out), 32'h0A5);
    write_one(12'h0C0);
    write_one(12'h0C1);
    write_one(12'h0C2);
    chk("pre_rst_count", 32'(fifo_count), 32'h3);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_data_out", 32'(data_out), 32'h0);
    chk("arst_stale", 32'(stale), 32'h1);
    chk("arst_count", 32'(fifo_count), 32'h0);
    chk("arst_update", 32'(out_update), 32'h0);
    chk("arst_state", 32'(state_dbg), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    slow_period(pulses, first_at, changes);
    chk("post_rst_pulses", 32'(pulses), 32'h0);
    chk("post_rst_data_out", 32'(data_out), 32'h0);
    chk("post_rst_stale", 32'(stale), 32'h1);
    chk("post_rst_state", 32'(state_dbg), 32'h0);
    write_one(12'h0D0);
    slow_period(pulses, first_at, changes);
    chk("post_rst_new_word", 32'(data_out), 32'h0D0);
    chk("post_rst_run", 32'(state_dbg), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
